// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite transfer types plus the stream writer FSM encoding.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StReq,
        StBeat,
        StWait,
        StDone
    } writer_state_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/stream_word_fifo.sv
// Synchronous word FIFO with push/pop, full/empty flags and an occupancy count.
module stream_word_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/stream_to_mem_dma_writer.sv
// Packs an 8-bit stream into little-endian words and bursts them to memory as an AHB3-lite master.
// Optional feature: define STREAM_DMA_CHECKSUM_EN to add the o_checksum XOR-of-written-words port.
module stream_to_mem_dma_writer
    import ahb3lite_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_Start,
    input  logic [15:0]       i_DMA_ADDR_HIGH,
    input  logic [15:0]       i_DMA_ADDR_LOW,
    input  logic [5:0]        i_BUFFER_LENGTH,
    input  logic [7:0]        i_serialized_input,
    input  logic              i_serialized_input_valid,
    output logic [1:0]        o_Deserialize_Counter,
    output logic [15:0]       o_Words_Counter,
    output logic [31:0]       mem_WR_addr,
    output logic              mem_write_flag,
    output logic [31:0]       HWDATA_toMem,
    input  logic              HREADY,
    output HTRANS_state       o_HTRANS,
    input  logic              slave_done,
`ifdef STREAM_DMA_CHECKSUM_EN
    output logic [31:0]       o_checksum,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = $clog2(BURST_LEN + 1);

    writer_state_e state_q, state_d;
    logic [31:0]   base_q;
    logic [5:0]    len_q;
    logic [15:0]   words_q, remaining, burst_need;
    logic [7:0]    bytes_q;
    logic [23:0]   partial_q;
    logic          overflow_q;
    logic [BW-1:0] beat_q, burst_q;

    logic          armed, byte_take, word_done, beat;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;

    assign armed      = (state_q != StIdle) && (state_q != StDone);
    assign byte_take  = armed && i_serialized_input_valid && (bytes_q != {len_q, 2'b00});
    assign word_done  = byte_take && (bytes_q[1:0] == 2'd3);
    assign beat       = (state_q == StBeat) && HREADY;
    assign remaining  = {10'b0, len_q} - words_q;
    assign burst_need = (remaining < 16'(BURST_LEN)) ? remaining : 16'(BURST_LEN);

    stream_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (word_done && !fifo_full),
        .wdata ({i_serialized_input, partial_q}),
        .pop   (beat),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        o_HTRANS = IDLE;
        unique case (state_q)
            StIdle: if (i_Start) state_d = (i_BUFFER_LENGTH == '0) ? StDone : StArm;
            StArm:  if ({{(16-CW){1'b0}}, fifo_count} >= burst_need) state_d = StReq;
            StReq: begin
                o_HTRANS = NONSEQ;
                if (HREADY) state_d = StBeat;
            end
            StBeat: begin
                o_HTRANS = (beat_q == '0) ? NONSEQ : SEQ;
                if (HREADY && (beat_q == burst_q - 1'b1)) state_d = StWait;
            end
            StWait: if (slave_done) state_d = (words_q == {10'b0, len_q}) ? StDone : StArm;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            base_q     <= '0;
            len_q      <= '0;
            words_q    <= '0;
            bytes_q    <= '0;
            partial_q  <= '0;
            overflow_q <= 1'b0;
            beat_q     <= '0;
            burst_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && i_Start) begin
                base_q     <= {i_DMA_ADDR_HIGH, i_DMA_ADDR_LOW};
                len_q      <= i_BUFFER_LENGTH;
                words_q    <= '0;
                bytes_q    <= '0;
                overflow_q <= 1'b0;
            end
            if (byte_take) begin
                bytes_q <= bytes_q + 1'b1;
                case (bytes_q[1:0])
                    2'd0:    partial_q[7:0]   <= i_serialized_input;
                    2'd1:    partial_q[15:8]  <= i_serialized_input;
                    2'd2:    partial_q[23:16] <= i_serialized_input;
                    default: partial_q        <= partial_q;
                endcase
            end
            if (word_done && fifo_full) overflow_q <= 1'b1;
            // Burst size is frozen at the ARM->REQ decision so late pushes cannot stretch it.
            if (state_q == StArm && state_d == StReq) begin
                burst_q <= burst_need[BW-1:0];
                beat_q  <= '0;
            end
            if (beat) begin
                beat_q <= beat_q + 1'b1;
                if (words_q != {10'b0, len_q}) words_q <= words_q + 1'b1;
            end
        end
    end

`ifdef STREAM_DMA_CHECKSUM_EN
    logic [31:0] checksum_q;
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            checksum_q <= '0;
        end else if (state_q == StIdle && i_Start) begin
            checksum_q <= '0;
        end else if (beat) begin
            checksum_q <= checksum_q ^ fifo_head;
        end
    end
    assign o_checksum = checksum_q;
`endif

    assign o_Deserialize_Counter = bytes_q[1:0];
    assign o_Words_Counter       = words_q;
    assign mem_WR_addr           = base_q + {14'b0, words_q, 2'b00};
    assign mem_write_flag        = beat;
    assign HWDATA_toMem          = (state_q == StBeat && !fifo_empty) ? fifo_head : '0;
    assign o_busy                = (state_q != StIdle);
    assign o_done                = (state_q == StDone);
    assign o_overflow            = overflow_q;

endmodule
